// File: rtl/frame_sequencer.sv
// Frame sequencer: divides a 512 Hz tick into length/sweep/envelope clocks
// and runs the channel length counter and the volume envelope.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   tick            - one-cycle 512 Hz strobe, advances the 8-step sequence
//   trigger         - one-cycle channel (re)start strobe
//   lengthLoad      - length register n; loaded length is 64 - n
//   lengthEnable    - length counter may switch the channel off
//   envInitVol      - volume loaded on trigger
//   envDir          - 1 = volume rises, 0 = volume falls
//   envPeriod       - envelope period in envClk steps, 0 = frozen
//   lengthClk       - pulse on steps 0, 2, 4, 6
//   sweepClk        - pulse on steps 2, 6
//   envClk          - pulse on step 7
//   volume          - current envelope volume
//   channelOn       - channel active flag
module frame_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       trigger,
    input  logic [5:0] lengthLoad,
    input  logic       lengthEnable,
    input  logic [3:0] envInitVol,
    input  logic       envDir,
    input  logic [2:0] envPeriod,
    output logic       lengthClk,
    output logic       sweepClk,
    output logic       envClk,
    output logic [3:0] volume,
    output logic       channelOn
);

    localparam logic [2:0] STEP_SWEEP_A = 3'd2;
    localparam logic [2:0] STEP_SWEEP_B = 3'd6;
    localparam logic [2:0] STEP_ENV     = 3'd7;

    logic [2:0] r_step;
    logic       r_lengthClk;
    logic       r_sweepClk;
    logic       r_envClk;
    logic [6:0] r_len;
    logic       r_on;
    logic [3:0] r_vol;
    logic [2:0] r_div;

    logic [6:0] w_len_load;
    logic       w_len_dec;
    logic       w_env_step;
    logic       w_div_wrap;
    logic [3:0] w_vol_next;

    // Step sequencer; pulses are decoded from the pre-increment step
    // and held for exactly the cycle following the tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step      <= 3'd0;
            r_lengthClk <= 1'b0;
            r_sweepClk  <= 1'b0;
            r_envClk    <= 1'b0;
        end else if (tick) begin
            r_step      <= r_step + 3'd1;
            r_lengthClk <= ~r_step[0];
            r_sweepClk  <= (r_step == STEP_SWEEP_A) ||
                           (r_step == STEP_SWEEP_B);
            r_envClk    <= (r_step == STEP_ENV);
        end else begin
            r_lengthClk <= 1'b0;
            r_sweepClk  <= 1'b0;
            r_envClk    <= 1'b0;
        end
    end

    // Length is 1..64, so it needs 7 bits.
    assign w_len_load = 7'd64 - {1'b0, lengthLoad};
    assign w_len_dec  = r_lengthClk && lengthEnable && (r_len != 7'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len <= 7'd0;
            r_on  <= 1'b0;
        end else if (trigger) begin
            r_len <= w_len_load;
            r_on  <= 1'b1;
        end else if (w_len_dec) begin
            r_len <= r_len - 7'd1;
            if (r_len == 7'd1)
                r_on <= 1'b0;
        end
    end

    // A divider of 1 is about to hit 0; a divider of 0 is treated the
    // same way, so both reload and step the volume.
    assign w_env_step = r_envClk && (envPeriod != 3'd0);
    assign w_div_wrap = (r_div <= 3'd1);

    always_comb begin
        w_vol_next = r_vol;
        if (envDir) begin
            if (r_vol != 4'd15)
                w_vol_next = r_vol + 4'd1;
        end else begin
            if (r_vol != 4'd0)
                w_vol_next = r_vol - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vol <= 4'd0;
            r_div <= 3'd0;
        end else if (trigger) begin
            r_vol <= envInitVol;
            r_div <= envPeriod;
        end else if (w_env_step) begin
            if (w_div_wrap) begin
                r_div <= envPeriod;
                r_vol <= w_vol_next;
            end else begin
                r_div <= r_div - 3'd1;
            end
        end
    end

    assign lengthClk = r_lengthClk;
    assign sweepClk  = r_sweepClk;
    assign envClk    = r_envClk;
    assign volume    = r_vol;
    assign channelOn = r_on;

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; forces all state to reset values immediately, independent of clk.
REQ-004 Port: tick  input  1  512 Hz strobe from the upstream fixed timer; high for exactly one clk cycle per period.
REQ-005 Port: trigger  input  1  one-cycle channel (re)start strobe.
REQ-006 Port: lengthLoad  input  6  length register value n; loaded length = 64 - n.
REQ-007 Port: lengthEnable  input  1  1 = length counter stops the channel when it expires.
REQ-008 Port: envInitVol  input  4  initial volume loaded on trigger.
REQ-009 Port: envDir  input  1  1 = volume increments, 0 = volume decrements.
REQ-010 Port: envPeriod  input  3  envelope period in envClk steps; 0 = envelope frozen.
REQ-011 Port: lengthClk  output  1  one-cycle pulse on sequencer steps 0, 2, 4, 6.
REQ-012 Port: sweepClk  output  1  one-cycle pulse on sequencer steps 2, 6.
REQ-013 Port: envClk  output  1  one-cycle pulse on sequencer step 7.
REQ-014 Port: volume  output  4  current envelope volume.
REQ-015 Port: channelOn  output  1  1 = channel active.

Function
REQ-016 3-bit step counter advances by 1 on every clk edge with tick=1; wraps 7 -> 0.
REQ-017 On tick edge E, pulses are decoded from step value before increment, registered, high for the single cycle after E, low otherwise (latency 1 clk from tick).
REQ-018 tick on consecutive cycles SHALL produce one step and one decoded pulse per tick cycle; no tick is dropped.
REQ-019 Length counter: 7-bit; trigger loads 64 - lengthLoad (range 1..64) and sets channelOn=1.
REQ-020 At an edge with lengthClk=1, lengthEnable=1, counter>0: counter decrements; on transition to 0, channelOn clears on that same edge.
REQ-021 lengthClk with lengthEnable=0 or counter=0: counter and channelOn unchanged.
REQ-022 Envelope: trigger loads volume=envInitVol and divider=envPeriod.
REQ-023 At an edge with envClk=1 and envPeriod!=0: divider decrements; if it reaches 0 (or was 0), divider reloads envPeriod and volume steps by 1 in envDir direction.
REQ-024 Volume saturates: no increment at 15, no decrement at 0; divider still reloads.
REQ-025 envPeriod=0: volume and divider unchanged on envClk.
REQ-026 trigger coincident with lengthClk or envClk: trigger load wins; that clock is ignored by the affected counter for that edge.
REQ-027 trigger coincident with tick: step counter still advances; trigger does not alter step counter.
REQ-028 envPeriod/envDir/lengthEnable changes take effect at the next relevant edge; no reload except on trigger.

Reset
REQ-029 reset=1: step=0, lengthClk=sweepClk=envClk=0, length counter=0, divider=0, volume=0, channelOn=0.
REQ-030 reset asserted mid-sequence SHALL discard pending pulses; after release, first tick decodes step 0 (lengthClk only).
REQ-031 tick and trigger while reset=1 SHALL have no effect.

Verification
REQ-032 Release reset, 8 ticks spaced 10 clks -> lengthClk after ticks 1,3,5,7; sweepClk after ticks 3,7; envClk after tick 8; each exactly 1 clk wide, 1 clk after tick.
REQ-033 trigger with lengthLoad=62, lengthEnable=1 -> channelOn=1; channelOn clears on 2nd lengthClk edge; further lengthClk keeps channelOn=0, counter=0.
REQ-034 trigger with envInitVol=2, envDir=0, envPeriod=1 -> volume 2,1,0,0 on successive envClk edges.
REQ-035 trigger with envInitVol=14, envDir=1, envPeriod=2 -> volume 15 after 2nd envClk, stays 15 after 4th; envPeriod=0 variant -> volume constant 14.
REQ-036 trigger asserted same cycle as envClk and as lengthClk -> volume=envInitVol, length=64-lengthLoad, no decrement that edge.
REQ-037 Assert reset asynchronously between clk edges after step 5 -> outputs 0 immediately; next tick after release yields lengthClk only.
